ad9914_cfg_seq: RTL and testbench
=================================

# ad9914_cfg_seq

Sequencer that owns the single AD9914 register-write engine (`ad9914_reg_wr`) and drives its load/busy/finish handshake. After reset it walks a fixed initialisation table of register writes, then serves runtime single-register update requests, such as frequency or phase words, from the control logic. With verification compiled in, it checks each write's read-back mismatch flag, retries failures and reports the failing entry.

## Interface
Parameters:
- `TABLE_DEPTH`, 16: number of init-table entries; index width is `$clog2(TABLE_DEPTH)`.
- `MAX_RETRY`, 3: extra attempts per write after a mismatch (verify build only).
- `AUTO_START`, 1: if 1, the init walk starts one cycle after reset release; if 0, it waits for `start`.

Ports (clock and reset first):
- `clk` in 1: single clock, shared with `ad9914_reg_wr`.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; restarts the init walk from entry 0. Honoured only in IDLE.
- `upd_req` in 1: runtime write request; held until `upd_ack`.
- `upd_addr` in 8: register base address.
- `upd_data` in 32: write value.
- `upd_byte_num` in 4: byte count, 1..4.
- `upd_ack` out 1: one-cycle pulse when the runtime write completes. Reset 0.
- `wr_load` out 1: to writer `load`. Reset 0.
- `wr_addr` out 8, `wr_wvar` out 32, `wr_byte_num` out 4: to the writer. Reset 0.
- `wr_res` in 1, `wr_busy` in 1, `wr_finish` in 1: from the writer.
- `init_done` out 1: high once the init table has completed without fatal error. Reset 0.
- `cfg_err` out 1: sticky fatal error; cleared by `start` or reset. Reset 0.
- `err_index` out idx-width: table index of the fatal entry; `TABLE_DEPTH-1` all-ones marks a runtime failure. Reset 0.
- `busy` out 1: high in any state except IDLE. Reset 0.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_ACC, WAIT_FIN, CHECK, NEXT.
- **IDLE**
  - After reset with `AUTO_START`=1, or on `start`: clear `index`, `cfg_err` and `init_done`; select the table; go to FETCH.
  - Else if `init_done` and `upd_req`: latch the `upd_*` fields; select runtime; go to ISSUE.
  - `upd_req` is ignored while `init_done`=0. Init has priority over runtime.
- **FETCH**: register the table entry `{addr[7:0], byte_num[3:0], data[31:0]}` at `index`; clear the retry counter; go to ISSUE.
- **ISSUE**: requires `wr_finish`=1. Drive `wr_*`, set `wr_load`=1, go to WAIT_ACC.
- **WAIT_ACC**: hold `wr_load` until `wr_busy`=1, then drop `wr_load` and go to WAIT_FIN.
- **WAIT_FIN**: on `wr_finish`=1 and `wr_busy`=0, go to CHECK.
- **CHECK**
  - With verify: if `wr_res`=1 and retry count < `MAX_RETRY`, increment the count and go to ISSUE.
  - If `wr_res`=1 and retries are exhausted: set `cfg_err`, load `err_index`, go to IDLE with `init_done`=0.
  - Otherwise go to NEXT.
- **NEXT**
  - Runtime write: pulse `upd_ack`, go to IDLE.
  - Table write: if `index`=`TABLE_DEPTH-1`, set `init_done` and go to IDLE; else increment `index` and go to FETCH.
- `byte_num`=0 in a table entry is a null entry: NEXT is taken directly from FETCH with no writer transaction.
- A runtime failure sets `cfg_err` but leaves `init_done` at 1.
- Reset mid-transaction returns to IDLE with all outputs at reset values. The writer is reset from the same `rst` domain.

## Timing
- `wr_load` rises one cycle after ISSUE is entered with `wr_finish`=1. It falls in the cycle after `wr_busy` is sampled high, so load never overlaps two accepts.
- The `wr_*` data buses stay stable from ISSUE until WAIT_FIN is left.
- Per-write overhead beyond the writer's own latency: 3 cycles (ISSUE, CHECK, NEXT), plus FETCH for table entries.
- `upd_ack` is high exactly one cycle, in the cycle after NEXT.
- `upd_req` sampled on the same cycle as `start` in IDLE: `start` wins; `upd_req` stays pending.

## Configuration
- `AD9914_CFG_VERIFY_EN` defined: `wr_res` is checked, with retries and `cfg_err` as described.
- Not defined: `wr_res` is ignored, CHECK always proceeds to NEXT, and `cfg_err`/`err_index` are tied 0. The retry counter is not built.

## Structure
- Shared package `ad9914_pkg`:
  - state enumeration;
  - table-entry struct (addr, byte_num, data);
  - AD9914 register address constants (CFR1–CFR4, DRG limits, profile registers).
- Sub-module `ad9914_cfg_rom`: combinational, indexed `TABLE_DEPTH`-entry table built from package constants. Swappable per board.

## Test plan
- Auto-start with a 4-entry table and a writer model that always returns `wr_res`=0 -> 4 accepted loads in index order; `init_done`=1 after the last finish; `cfg_err`=0.
- Writer model returns `wr_res`=1 twice on entry 2, `MAX_RETRY`=3 -> entry 2 issued 3 times; `init_done`=1; `cfg_err`=0.
- Writer model always returns `wr_res`=1 on entry 1 -> 4 attempts; then `cfg_err`=1, `err_index`=1, `init_done`=0, no further loads. Repeat without the macro -> `init_done`=1.
- After init, `upd_req` with addr 0x0B, data 0x12345678, byte_num 4 -> one load carrying those values; `upd_ack` pulses once; `busy` returns to 0.
- `start` and `upd_req` asserted together in IDLE -> table walk first, then the update is served; `upd_ack` arrives after `init_done`.
- `rst` asserted during WAIT_FIN -> all outputs 0 in the same cycle; a fresh auto-start walk begins from entry 0 on release.

Source files
------------

// File: rtl/ad9914_pkg.sv
// Shared types and AD9914 register map for the configuration sequencer.
package ad9914_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_ACC,
        ST_WAIT_FIN,
        ST_CHECK,
        ST_NEXT
    } cfg_state_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  byte_num;
        logic [31:0] data;
    } cfg_entry_t;

    localparam logic [7:0] REG_CFR1          = 8'h00;
    localparam logic [7:0] REG_CFR2          = 8'h01;
    localparam logic [7:0] REG_CFR3          = 8'h02;
    localparam logic [7:0] REG_CFR4          = 8'h03;
    localparam logic [7:0] REG_DRG_LOWER     = 8'h04;
    localparam logic [7:0] REG_DRG_UPPER     = 8'h05;
    localparam logic [7:0] REG_DRG_RISE_STEP = 8'h06;
    localparam logic [7:0] REG_DRG_FALL_STEP = 8'h07;
    localparam logic [7:0] REG_DRG_RATE      = 8'h08;
    localparam logic [7:0] REG_PROF0_FTW     = 8'h0B;
    localparam logic [7:0] REG_PROF0_PAW     = 8'h0C;

    function automatic cfg_entry_t mk_entry(input logic [7:0] addr,
                                            input logic [3:0] byte_num,
                                            input logic [31:0] data);
        cfg_entry_t e;
        e.addr     = addr;
        e.byte_num = byte_num;
        e.data     = data;
        return e;
    endfunction

endpackage

// File: rtl/ad9914_cfg_rom.sv
// Board init table for the AD9914; indices without an entry read as null (byte_num 0).
module ad9914_cfg_rom
    import ad9914_pkg::*;
#(
    parameter int unsigned IW = 4
)(
    input  logic [IW-1:0] index_i,
    output cfg_entry_t    entry_o
);

    int unsigned idx;
    assign idx = 32'(index_i);

    always_comb begin
        entry_o = '0;
        case (idx)
            0:  entry_o = mk_entry(REG_CFR1,          4'd4, 32'h0001_0008);
            1:  entry_o = mk_entry(REG_CFR2,          4'd4, 32'h0080_0900);
            2:  entry_o = mk_entry(REG_CFR3,          4'd4, 32'h0000_1C19);
            3:  entry_o = mk_entry(REG_CFR4,          4'd4, 32'h0005_0120);
            4:  entry_o = mk_entry(REG_DRG_LOWER,     4'd4, 32'h0000_0000);
            5:  entry_o = mk_entry(REG_DRG_UPPER,     4'd4, 32'hFFFF_FFFF);
            6:  entry_o = mk_entry(REG_DRG_RISE_STEP, 4'd4, 32'h0000_0100);
            7:  entry_o = mk_entry(REG_DRG_FALL_STEP, 4'd4, 32'h0000_0100);
            8:  entry_o = mk_entry(REG_DRG_RATE,      4'd4, 32'h0001_0001);
            9:  entry_o = mk_entry(REG_PROF0_FTW,     4'd4, 32'h1999_999A);
            10: entry_o = mk_entry(REG_PROF0_PAW,     4'd4, 32'h0FFF_0000);
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/ad9914_cfg_seq.sv
// AD9914 init-table walker and runtime register-update sequencer for ad9914_reg_wr.
// Define AD9914_CFG_VERIFY_EN to check wr_res, retry mismatches and report cfg_err/err_index.
module ad9914_cfg_seq
    import ad9914_pkg::*;
#(
    parameter int unsigned TABLE_DEPTH = 16,
    parameter int unsigned MAX_RETRY   = 3,
    parameter bit          AUTO_START  = 1'b1,
    localparam int unsigned IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          upd_req,
    input  logic [7:0]    upd_addr,
    input  logic [31:0]   upd_data,
    input  logic [3:0]    upd_byte_num,
    output logic          upd_ack,
    output logic          wr_load,
    output logic [7:0]    wr_addr,
    output logic [31:0]   wr_wvar,
    output logic [3:0]    wr_byte_num,
    input  logic          wr_res,
    input  logic          wr_busy,
    input  logic          wr_finish,
    output logic          init_done,
    output logic          cfg_err,
    output logic [IW-1:0] err_index,
    output logic          busy
);

    cfg_state_e    state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    cfg_entry_t    entry_q, entry_d;
    cfg_entry_t    rom_entry;
    logic          rt_q, rt_d;
    logic          auto_q, auto_d;
    logic          wr_load_q, wr_load_d;
    logic          upd_ack_q, upd_ack_d;
    logic          init_done_q, init_done_d;

`ifdef AD9914_CFG_VERIFY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    logic          cfg_err_q, cfg_err_d;
    logic [IW-1:0] err_index_q, err_index_d;
`else
    logic          unused_nv;
    assign unused_nv = wr_res | (MAX_RETRY == 0);
`endif

    ad9914_cfg_rom #(.IW(IW)) u_rom (
        .index_i (index_q),
        .entry_o (rom_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            entry_q     <= '0;
            rt_q        <= 1'b0;
            auto_q      <= AUTO_START;
            wr_load_q   <= 1'b0;
            upd_ack_q   <= 1'b0;
            init_done_q <= 1'b0;
`ifdef AD9914_CFG_VERIFY_EN
            retry_q     <= '0;
            cfg_err_q   <= 1'b0;
            err_index_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            entry_q     <= entry_d;
            rt_q        <= rt_d;
            auto_q      <= auto_d;
            wr_load_q   <= wr_load_d;
            upd_ack_q   <= upd_ack_d;
            init_done_q <= init_done_d;
`ifdef AD9914_CFG_VERIFY_EN
            retry_q     <= retry_d;
            cfg_err_q   <= cfg_err_d;
            err_index_q <= err_index_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        entry_d     = entry_q;
        rt_d        = rt_q;
        auto_d      = auto_q;
        wr_load_d   = wr_load_q;
        upd_ack_d   = 1'b0;
        init_done_d = init_done_q;
`ifdef AD9914_CFG_VERIFY_EN
        retry_d     = retry_q;
        cfg_err_d   = cfg_err_q;
        err_index_d = err_index_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A pending init walk always beats a runtime request held alongside it.
                if (auto_q || start) begin
                    auto_d      = 1'b0;
                    index_d     = '0;
                    init_done_d = 1'b0;
                    rt_d        = 1'b0;
`ifdef AD9914_CFG_VERIFY_EN
                    cfg_err_d   = 1'b0;
`endif
                    state_d     = ST_FETCH;
                end else if (init_done_q && upd_req) begin
                    entry_d = mk_entry(upd_addr, upd_byte_num, upd_data);
                    rt_d    = 1'b1;
`ifdef AD9914_CFG_VERIFY_EN
                    retry_d = '0;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_FETCH: begin
                entry_d = rom_entry;
`ifdef AD9914_CFG_VERIFY_EN
                retry_d = '0;
`endif
                state_d = (rom_entry.byte_num == 4'd0) ? ST_NEXT : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (wr_finish) begin
                    wr_load_d = 1'b1;
                    state_d   = ST_WAIT_ACC;
                end
            end
            ST_WAIT_ACC: begin
                if (wr_busy) begin
                    wr_load_d = 1'b0;
                    state_d   = ST_WAIT_FIN;
                end
            end
            ST_WAIT_FIN: begin
                if (wr_finish && !wr_busy) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_NEXT;
`ifdef AD9914_CFG_VERIFY_EN
                if (wr_res) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        cfg_err_d   = 1'b1;
                        err_index_d = rt_q ? '1 : index_q;
                        state_d     = ST_IDLE;
                    end
                end
`endif
            end
            ST_NEXT: begin
                if (rt_q) begin
                    upd_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (index_q == IW'(TABLE_DEPTH - 1)) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign upd_ack     = upd_ack_q;
    assign wr_load     = wr_load_q;
    assign wr_addr     = entry_q.addr;
    assign wr_wvar     = entry_q.data;
    assign wr_byte_num = entry_q.byte_num;
    assign init_done   = init_done_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef AD9914_CFG_VERIFY_EN
    assign cfg_err     = cfg_err_q;
    assign err_index   = err_index_q;
`else
    assign cfg_err     = 1'b0;
    assign err_index   = '0;
`endif

endmodule

// File: tb/tb_ad9914_cfg_seq.sv
// Scoreboard bench for ad9914_cfg_seq with a 4-entry table and a behavioural writer model.
module tb_ad9914_cfg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        upd_req = 1'b0;
    logic [7:0]  upd_addr = 8'h00;
    logic [31:0] upd_data = 32'h0;
    logic [3:0]  upd_byte_num = 4'h0;
    logic        upd_ack, wr_load, init_done, cfg_err, busy;
    logic [7:0]  wr_addr;
    logic [31:0] wr_wvar;
    logic [3:0]  wr_byte_num;
    logic [1:0]  err_index;
    logic        mb, mf, mr;

    int checks = 0;
    int errors = 0;
    int loads  = 0;

    ad9914_cfg_seq #(
        .TABLE_DEPTH (4),
        .MAX_RETRY   (3),
        .AUTO_START  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .upd_req      (upd_req),
        .upd_addr     (upd_addr),
        .upd_data     (upd_data),
        .upd_byte_num (upd_byte_num),
        .upd_ack      (upd_ack),
        .wr_load      (wr_load),
        .wr_addr      (wr_addr),
        .wr_wvar      (wr_wvar),
        .wr_byte_num  (wr_byte_num),
        .wr_res       (mr),
        .wr_busy      (mb),
        .wr_finish    (mf),
        .init_done    (init_done),
        .cfg_err      (cfg_err),
        .err_index    (err_index),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Writer model: accepts load when idle, busy for 3 cycles, then finish with a scripted wr_res.
    int         mcnt;
    int         att;
    int         fail_n = 0;
    logic [7:0] fail_addr = 8'hFF;
    logic [7:0] cur_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb <= 1'b0; mf <= 1'b1; mr <= 1'b0; mcnt <= 0; cur_addr <= 8'h00; att <= 0;
        end else if (!mb) begin
            if (wr_load) begin
                mb <= 1'b1; mf <= 1'b0; mr <= 1'b0; mcnt <= 3; cur_addr <= wr_addr;
            end
        end else if (mcnt == 1) begin
            mb <= 1'b0;
            mf <= 1'b1;
            mr <= (cur_addr == fail_addr) && (att < fail_n);
            if (cur_addr == fail_addr) att <= att + 1;
        end else begin
            mcnt <= mcnt - 1;
        end
    end

    localparam logic [43:0] E0  = {8'h00, 4'h4, 32'h0001_0008};
    localparam logic [43:0] E1  = {8'h01, 4'h4, 32'h0080_0900};
    localparam logic [43:0] E2  = {8'h02, 4'h4, 32'h0000_1C19};
    localparam logic [43:0] E3  = {8'h03, 4'h4, 32'h0005_0120};
    localparam logic [43:0] UPA = {8'h0B, 4'h4, 32'h1234_5678};
    localparam logic [43:0] UPB = {8'h0B, 4'h3, 32'hCAFE_F00D};

    logic [43:0] exp_q[$];
    logic [43:0] mon_exp, mon_got;
    logic        prev_load = 1'b0;

    always @(negedge clk) begin
        if (wr_load && !prev_load) begin
            loads++;
            checks++;
            mon_got = {wr_addr, wr_byte_num, wr_wvar};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL load_fields got %h expected %h", mon_got, mon_exp);
                end
            end
        end
        prev_load = wr_load;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return init_done;
            1:       return cfg_err;
            default: return upd_ack;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(sel) === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout got 0 expected 1", name);
    endtask

    task automatic push_table();
        exp_q.push_back(E0); exp_q.push_back(E1); exp_q.push_back(E2); exp_q.push_back(E3);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({upd_ack, wr_load, wr_addr, wr_wvar, wr_byte_num, init_done, cfg_err, err_index, busy});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values and a clean auto-start walk.
        do_reset();
        chk("reset_outputs", all_outs(), 64'h0);
        push_table();
        rst = 1'b1;
        wait_sig(0, 300, "walk_init_done");
        chk("walk_cfg_err", 64'(cfg_err), 64'h0);
        chk("walk_busy", 64'(busy), 64'h0);
        chk("walk_sb_empty", 64'(exp_q.size()), 64'h0);
        chk("walk_loads", 64'(loads), 64'd4);

        // Two mismatches on entry 2 recover within the retry budget.
        do_reset();
        fail_addr = 8'h02; fail_n = 2;
        exp_q.push_back(E0); exp_q.push_back(E1); exp_q.push_back(E2);
`ifdef AD9914_CFG_VERIFY_EN
        exp_q.push_back(E2); exp_q.push_back(E2);
`endif
        exp_q.push_back(E3);
        rst = 1'b1;
        wait_sig(0, 400, "retry_init_done");
        chk("retry_cfg_err", 64'(cfg_err), 64'h0);
        chk("retry_sb_empty", 64'(exp_q.size()), 64'h0);

        // Persistent mismatch on entry 1.
        do_reset();
        fail_addr = 8'h01; fail_n = 255;
`ifdef AD9914_CFG_VERIFY_EN
        exp_q.push_back(E0);
        repeat (4) exp_q.push_back(E1);
        rst = 1'b1;
        wait_sig(1, 400, "fatal_cfg_err");
        chk("fatal_err_index", 64'(err_index), 64'h1);
        chk("fatal_init_done", 64'(init_done), 64'h0);
        chk("fatal_busy", 64'(busy), 64'h0);
        begin
            int l0;
            l0 = loads;
            repeat (30) @(negedge clk);
            chk("fatal_no_more_loads", 64'(loads), 64'(l0));
        end
`else
        push_table();
        rst = 1'b1;
        wait_sig(0, 400, "noverify_init_done");
        chk("noverify_cfg_err", 64'(cfg_err), 64'h0);
        chk("noverify_err_index", 64'(err_index), 64'h0);
`endif

        // start re-walks the table and clears any error.
        fail_n = 0;
        push_table();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_cfg_err", 64'(cfg_err), 64'h0);
        wait_sig(0, 300, "start_init_done");
        chk("start_sb_empty", 64'(exp_q.size()), 64'h0);

        // Runtime update.
        upd_addr = 8'h0B; upd_data = 32'h1234_5678; upd_byte_num = 4'h4;
        exp_q.push_back(UPA);
        upd_req = 1'b1;
        wait_sig(2, 100, "upd_ack");
        upd_req = 1'b0;
        chk("upd_busy_at_ack", 64'(busy), 64'h0);
        chk("upd_init_done", 64'(init_done), 64'h1);
        @(negedge clk);
        chk("upd_ack_one_cycle", 64'(upd_ack), 64'h0);
        chk("upd_sb_empty", 64'(exp_q.size()), 64'h0);

        // Runtime write that keeps mismatching.
        fail_addr = 8'h0B; fail_n = 255;
`ifdef AD9914_CFG_VERIFY_EN
        repeat (4) exp_q.push_back(UPA);
        upd_req = 1'b1;
        wait_sig(1, 200, "rt_fail_cfg_err");
        upd_req = 1'b0;
        chk("rt_fail_err_index", 64'(err_index), 64'h3);
        chk("rt_fail_init_done", 64'(init_done), 64'h1);
        chk("rt_fail_no_ack", 64'(upd_ack), 64'h0);
`else
        exp_q.push_back(UPA);
        upd_req = 1'b1;
        wait_sig(2, 100, "rt_fail_ack");
        upd_req = 1'b0;
        chk("rt_fail_cfg_err", 64'(cfg_err), 64'h0);
`endif
        repeat (3) @(negedge clk);
        fail_n = 0;

        // start and upd_req together: table walk first, update afterwards.
        push_table();
        exp_q.push_back(UPB);
        upd_addr = 8'h0B; upd_data = 32'hCAFE_F00D; upd_byte_num = 4'h3;
        start = 1'b1;
        upd_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("both_init_done_cleared", 64'(init_done), 64'h0);
        chk("both_cfg_err_cleared", 64'(cfg_err), 64'h0);
        wait_sig(2, 400, "both_upd_ack");
        upd_req = 1'b0;
        chk("both_init_done_at_ack", 64'(init_done), 64'h1);
        chk("both_sb_empty", 64'(exp_q.size()), 64'h0);

        // Reset while the first table write sits in WAIT_FIN.
        do_reset();
        exp_q.push_back(E0);
        rst = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (mb && !wr_load && busy) seen = 1'b1;
            end
            chk("midrst_reached_wait_fin", 64'(seen), 64'h1);
        end
        rst = 1'b0;
        #1;
        chk("midrst_outputs", all_outs(), 64'h0);
        exp_q.delete();
        @(negedge clk);
        push_table();
        rst = 1'b1;
        wait_sig(0, 300, "midrst_init_done");
        chk("midrst_sb_empty", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
